// File: rtl/i2c_receptor_transacciones.sv
// I2C target: decodes START/STOP, matches OWN_ADDR, receives a 16-bit write word or serializes a 16-bit read word.
// SCL/SDA are oversampled on clk; SDA_OUT/SDA_OE only move on SCL falls (or START/STOP/reset).
module i2c_receptor_transacciones #(
  parameter logic [6:0] OWN_ADDR = 7'h2A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  input  logic        SDA_IN,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  input  logic [15:0] RD_DATA,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_STB,
  output logic        BUSY
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ACK_ADDR  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] ACK_WR    = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] MACK      = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  logic        scl_q, sda_q;
  logic [2:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        byte_cnt_q, byte_cnt_d;
  logic        ack_ph_q, ack_ph_d;
  logic        rw_q, rw_d;
  logic [14:0] shift_q, shift_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        sda_out_q, sda_out_d;
  logic        sda_oe_q, sda_oe_d;
  logic        wr_stb_q, wr_stb_d;
  logic        rd_stb_q, rd_stb_d;
  logic        busy_q, busy_d;

  logic rise, fall, start, stop;

  assign rise  = SCL & ~scl_q;
  assign fall  = ~SCL & scl_q;
  assign start = SCL & scl_q & sda_q & ~SDA_IN;
  assign stop  = SCL & scl_q & ~sda_q & SDA_IN;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    ack_ph_d   = ack_ph_q;
    rw_d       = rw_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    wr_data_d  = wr_data_q;
    sda_out_d  = sda_out_q;
    sda_oe_d   = sda_oe_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    busy_d     = busy_q;

    if (stop) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      sda_out_d = 1'b1;
      busy_d    = 1'b0;
    end else if (start) begin
      // Repeated start drops any partial word; WR_DATA is left untouched.
      state_d    = ADDR;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 1'b0;
      ack_ph_d   = 1'b0;
      sda_oe_d   = 1'b0;
      sda_out_d  = 1'b1;
      busy_d     = 1'b0;
    end else if (!(rise && fall)) begin
      case (state_q)
        IDLE: ;
        ADDR: if (rise) begin
          shift_d   = {shift_q[13:0], SDA_IN};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rw_d = SDA_IN;
            if (shift_q[6:0] == OWN_ADDR) begin
              state_d  = ACK_ADDR;
              busy_d   = 1'b1;
              ack_ph_d = 1'b0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ACK_ADDR: if (fall) begin
          if (!ack_ph_q) begin
            ack_ph_d  = 1'b1;
            sda_oe_d  = 1'b1;
            sda_out_d = 1'b0;
          end else begin
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              state_d   = READ;
              tx_d      = {RD_DATA[14:0], 1'b0};
              sda_out_d = RD_DATA[15];
              sda_oe_d  = 1'b1;
              rd_stb_d  = 1'b1;
            end else begin
              state_d   = WRITE;
              sda_oe_d  = 1'b0;
              sda_out_d = 1'b1;
            end
          end
        end
        WRITE: if (rise) begin
          shift_d   = {shift_q[13:0], SDA_IN};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d  = ACK_WR;
            ack_ph_d = 1'b0;
            if (byte_cnt_q) begin
              wr_data_d = {shift_q, SDA_IN};
              wr_stb_d  = 1'b1;
            end
          end
        end
        ACK_WR: if (fall) begin
          if (!ack_ph_q) begin
            ack_ph_d  = 1'b1;
            sda_oe_d  = 1'b1;
            sda_out_d = 1'b0;
          end else begin
            ack_ph_d  = 1'b0;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b1;
            if (!byte_cnt_q) begin
              state_d    = WRITE;
              byte_cnt_d = 1'b1;
              bit_cnt_d  = 3'd0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        READ: if (fall) begin
          if (bit_cnt_q == 3'd7) begin
            state_d   = MACK;
            ack_ph_d  = 1'b0;
            sda_oe_d  = 1'b0;
            sda_out_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            sda_out_d = tx_q[15];
            tx_d      = {tx_q[14:0], 1'b0};
          end
        end
        MACK: begin
          // ack_ph marks "controller ACKed byte 0, drive bit 8 at the next fall".
          if (rise && !ack_ph_q) begin
            if (!byte_cnt_q && !SDA_IN) begin
              ack_ph_d   = 1'b1;
              byte_cnt_d = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (fall && ack_ph_q) begin
            state_d   = READ;
            ack_ph_d  = 1'b0;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b1;
            sda_out_d = tx_q[15];
            tx_d      = {tx_q[14:0], 1'b0};
          end
        end
        WAIT_STOP: begin
          sda_oe_d  = 1'b0;
          sda_out_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 1'b0;
      ack_ph_q   <= 1'b0;
      rw_q       <= 1'b0;
      shift_q    <= '0;
      tx_q       <= '0;
      wr_data_q  <= '0;
      sda_out_q  <= 1'b1;
      sda_oe_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      scl_q      <= SCL;
      sda_q      <= SDA_IN;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      ack_ph_q   <= ack_ph_d;
      rw_q       <= rw_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_data_q  <= wr_data_d;
      sda_out_q  <= sda_out_d;
      sda_oe_q   <= sda_oe_d;
      wr_stb_q   <= wr_stb_d;
      rd_stb_q   <= rd_stb_d;
      busy_q     <= busy_d;
    end
  end

  assign SDA_OUT = sda_out_q;
  assign SDA_OE  = sda_oe_q;
  assign WR_DATA = wr_data_q;
  assign WR_STB  = wr_stb_q;
  assign RD_STB  = rd_stb_q;
  assign BUSY    = busy_q;

endmodule

// File: tb/tb_i2c_receptor_transacciones.sv
// Directed bench for the I2C target: write, read, address mismatch, NACK, repeated start, mid-ACK reset.
module tb_i2c_receptor_transacciones;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        gen_sda = 1'b1;
  logic [15:0] rd_data = 16'h0000;
  wire         sda_bus;
  logic        sda_out, sda_oe, wr_stb, rd_stb, busy;
  logic [15:0] wr_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_stb_cnt = 0;
  int rd_stb_cnt = 0;
  int oe_cnt = 0;
  int busy_cnt = 0;
  logic stb_seen = 1'b0;

  // Open-drain resolution: target can only pull the bus low.
  assign sda_bus = gen_sda & (sda_oe ? sda_out : 1'b1);

  always #5 clk = ~clk;

  i2c_receptor_transacciones #(.OWN_ADDR(7'h2A)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .SCL     (scl),
    .SDA_IN  (sda_bus),
    .SDA_OUT (sda_out),
    .SDA_OE  (sda_oe),
    .RD_DATA (rd_data),
    .WR_DATA (wr_data),
    .WR_STB  (wr_stb),
    .RD_STB  (rd_stb),
    .BUSY    (busy)
  );

  always @(posedge clk) begin
    if (wr_stb) wr_stb_cnt++;
    if (rd_stb) rd_stb_cnt++;
    if (sda_oe) oe_cnt++;
    if (busy)   busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One SCL period (2 clk low, 2 clk high); samples target outputs just after the rise.
  task automatic clk_bit(input logic b, output logic oe, output logic dout);
    scl = 1'b0;
    tick;
    gen_sda = b;
    tick;
    scl = 1'b1;
    tick;
    oe = sda_oe;
    dout = sda_out;
    stb_seen = wr_stb;
    tick;
  endtask

  task automatic send_byte(input logic [7:0] v);
    logic oe, d;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], oe, d);
  endtask

  task automatic ack_slot(input string tag);
    logic oe, d;
    clk_bit(1'b1, oe, d);
    chk({tag, "_oe"}, {31'd0, oe}, 32'd1);
    chk({tag, "_sda"}, {31'd0, d}, 32'd0);
  endtask

  task automatic recv_byte(output logic [7:0] v, output logic all_oe);
    logic oe, d;
    all_oe = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, oe, d);
      v[i] = d;
      all_oe = all_oe & oe;
    end
  endtask

  task automatic start_cond;
    scl = 1'b0;
    tick;
    gen_sda = 1'b1;
    tick;
    scl = 1'b1;
    tick;
    tick;
    gen_sda = 1'b0;
    tick;
    tick;
  endtask

  task automatic stop_cond(output logic busy_before, output logic busy_after);
    scl = 1'b0;
    tick;
    gen_sda = 1'b0;
    tick;
    scl = 1'b1;
    tick;
    tick;
    busy_before = busy;
    gen_sda = 1'b1;
    tick;
    busy_after = busy;
    tick;
  endtask

  task automatic write_word(input logic [7:0] addr_byte, input logic [15:0] w, input string tag);
    send_byte(addr_byte);
    ack_slot({tag, "_ack9"});
    send_byte(w[15:8]);
    ack_slot({tag, "_ack18"});
    send_byte(w[7:0]);
    chk({tag, "_stb_after_rise16"}, {31'd0, stb_seen}, 32'd1);
    ack_slot({tag, "_ack27"});
  endtask

  initial begin
    logic bb, ba, oe, d, all_oe;
    logic [7:0] rb;
    int s_wr, s_rd, s_oe, s_busy;

    // Reset state
    tick; tick; tick;
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_sda_out", {31'd0, sda_out}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data}, 32'h0000);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_rd_stb", {31'd0, rd_stb}, 32'd0);
    rst_n = 1'b1;
    tick; tick;

    // Write 0xA55A to 0x2A
    s_wr = wr_stb_cnt;
    start_cond;
    write_word(8'h54, 16'hA55A, "wr1");
    stop_cond(bb, ba);
    chk("wr1_wr_data", {16'd0, wr_data}, 32'hA55A);
    chk("wr1_stb_count", wr_stb_cnt - s_wr, 32'd1);
    chk("wr1_busy_before_stop", {31'd0, bb}, 32'd1);
    chk("wr1_busy_after_stop", {31'd0, ba}, 32'd0);
    chk("wr1_oe_after_stop", {31'd0, sda_oe}, 32'd0);

    // Read 0x3C81, controller ACKs byte 0, NACKs byte 1
    rd_data = 16'h3C81;
    s_rd = rd_stb_cnt;
    start_cond;
    send_byte(8'h55);
    ack_slot("rd1_ack9");
    recv_byte(rb, all_oe);
    chk("rd1_byte0", {24'd0, rb}, 32'h3C);
    chk("rd1_byte0_oe", {31'd0, all_oe}, 32'd1);
    clk_bit(1'b0, oe, d);
    chk("rd1_mack0_oe", {31'd0, oe}, 32'd0);
    recv_byte(rb, all_oe);
    chk("rd1_byte1", {24'd0, rb}, 32'h81);
    chk("rd1_byte1_oe", {31'd0, all_oe}, 32'd1);
    clk_bit(1'b1, oe, d);
    chk("rd1_mack1_oe", {31'd0, oe}, 32'd0);
    stop_cond(bb, ba);
    chk("rd1_stb_count", rd_stb_cnt - s_rd, 32'd1);
    chk("rd1_busy_after_stop", {31'd0, ba}, 32'd0);
    chk("rd1_oe_after_stop", {31'd0, sda_oe}, 32'd0);

    // Address 0x15: nobody answers
    s_wr = wr_stb_cnt; s_oe = oe_cnt; s_busy = busy_cnt;
    start_cond;
    send_byte(8'h2A);
    clk_bit(1'b1, oe, d);
    send_byte(8'hA5);
    clk_bit(1'b1, oe, d);
    send_byte(8'h5A);
    clk_bit(1'b1, oe, d);
    stop_cond(bb, ba);
    chk("miss_oe_cycles", oe_cnt - s_oe, 32'd0);
    chk("miss_busy_cycles", busy_cnt - s_busy, 32'd0);
    chk("miss_stb_count", wr_stb_cnt - s_wr, 32'd0);
    chk("miss_wr_data", {16'd0, wr_data}, 32'hA55A);

    // Read with NACK after byte 0, then a write of 0x0001
    rd_data = 16'hF00F;
    start_cond;
    send_byte(8'h55);
    ack_slot("rd2_ack9");
    recv_byte(rb, all_oe);
    chk("rd2_byte0", {24'd0, rb}, 32'hF0);
    clk_bit(1'b1, oe, d);
    chk("rd2_nack_oe", {31'd0, oe}, 32'd0);
    s_oe = oe_cnt;
    for (int i = 0; i < 9; i++) clk_bit(1'b1, oe, d);
    stop_cond(bb, ba);
    chk("rd2_oe_cycles_after_nack", oe_cnt - s_oe, 32'd0);
    s_wr = wr_stb_cnt;
    start_cond;
    write_word(8'h54, 16'h0001, "wr2");
    stop_cond(bb, ba);
    chk("wr2_wr_data", {16'd0, wr_data}, 32'h0001);
    chk("wr2_stb_count", wr_stb_cnt - s_wr, 32'd1);

    // Repeated START after 5 bits of byte 1, then a full write of 0x1234
    s_wr = wr_stb_cnt;
    start_cond;
    send_byte(8'h54);
    ack_slot("rs_ack9");
    send_byte(8'hFF);
    ack_slot("rs_ack18");
    for (int i = 0; i < 5; i++) clk_bit(i[0] ? 1'b0 : 1'b1, oe, d);
    start_cond;
    chk("rs_abort_stb_count", wr_stb_cnt - s_wr, 32'd0);
    chk("rs_abort_wr_data", {16'd0, wr_data}, 32'h0001);
    write_word(8'h54, 16'h1234, "rs");
    stop_cond(bb, ba);
    chk("rs_wr_data", {16'd0, wr_data}, 32'h1234);
    chk("rs_stb_count", wr_stb_cnt - s_wr, 32'd1);

    // Reset while the target drives the address ACK
    start_cond;
    send_byte(8'h54);
    scl = 1'b0;
    tick;
    tick;
    chk("rst_mid_ack_oe", {31'd0, sda_oe}, 32'd1);
    chk("rst_mid_ack_sda", {31'd0, sda_out}, 32'd0);
    rst_n = 1'b0;
    tick;
    chk("rst_mid_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_mid_sda_out", {31'd0, sda_out}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_wr_data", {16'd0, wr_data}, 32'h0000);
    chk("rst_mid_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_mid_rd_stb", {31'd0, rd_stb}, 32'd0);
    rst_n = 1'b1;
    gen_sda = 1'b1;
    tick;
    scl = 1'b1;
    tick;
    tick;
    s_oe = oe_cnt;
    for (int i = 0; i < 9; i++) clk_bit(1'b0, oe, d);
    chk("rst_idle_no_oe", oe_cnt - s_oe, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_receptor_transacciones.md
Name: i2c_receptor_transacciones

Overview:
- I2C target (receptor) block: the far end of the bus from the I2C transaction generator.
- Decodes START and STOP conditions and matches its own 7-bit address.
- On a write it receives 16 data bits and exposes them on WR_DATA; on a read it serializes 16 bits from RD_DATA.
- Drives ACK and read data through an SDA_OUT/SDA_OE pair, and oversamples SCL/SDA with the system clock.

Parameters:
- OWN_ADDR, 7'h2A, address this target answers to.

Ports:
- clk  in  1  system clock; SCL/SDA_IN are synchronous to it. SCL high and low phases are each at least 2 clk cycles (generator SCL = clk/4).
- rst  in  1  synchronous, active-low reset.
- SCL  in  1  bus clock from the generator.
- SDA_IN  in  1  resolved SDA bus value.
- SDA_OUT  out  1  serial data/ACK driven by the target.
- SDA_OE  out  1  1 = target owns SDA. Asserted only during target ACK slots and read-data bits.
- RD_DATA  in  16  word returned on a read. Captured when the address phase completes.
- WR_DATA  out  16  last word received on a write.
- WR_STB  out  1  1-clk pulse; WR_DATA has just been updated.
- RD_STB  out  1  1-clk pulse; RD_DATA has just been captured for transmission.
- BUSY  out  1  1 from an address-matched START until STOP/return to IDLE.

Behaviour:
- Input registers: scl_d and sda_d hold the previous-cycle values of SCL and SDA_IN.
- Event decode:
  - rise = SCL & ~scl_d; fall = ~SCL & scl_d.
  - START = SCL & scl_d & sda_d & ~SDA_IN.
  - STOP = SCL & scl_d & ~sda_d & SDA_IN.
- Data sampling: SDA_IN is sampled in the rise cycle. SDA_OUT/SDA_OE change only in fall cycles, except STOP/START/reset release.
- Reset values: SDA_OUT=1, SDA_OE=0, WR_DATA=0, WR_STB=0, RD_STB=0, BUSY=0, state=IDLE, all counters 0.
- Bit order: MSB first everywhere. bit_cnt is 0..7 within a byte; byte_cnt is 0..1.
- States:
  - IDLE: waits for START.
  - ADDR: shifts in 8 bits on rises (7 address + R/W).
    - After the 8th rise: if addr == OWN_ADDR, go to ACK_ADDR and set BUSY=1.
    - Otherwise go to WAIT_STOP; SDA_OE stays 0 (NACK by silence).
  - ACK_ADDR: at the next fall, SDA_OE=1, SDA_OUT=0. Hold through one SCL high period. At the following fall:
    - Write (R/W=0): go to WRITE; release SDA_OE=0, SDA_OUT=1.
    - Read (R/W=1): go to READ; capture RD_DATA into the tx shift register, pulse RD_STB, and drive the MSB with SDA_OE=1 in that same fall cycle.
  - WRITE: shifts SDA_IN into the rx shift register on each rise.
    - After the 8th rise of byte 0: go to ACK_WR.
    - After the 8th rise of byte 1: load WR_DATA with all 16 bits and pulse WR_STB in the cycle after that rise, then go to ACK_WR.
  - ACK_WR: drives ACK (SDA_OE=1, SDA_OUT=0) from the next fall to the following fall, then releases.
    - Byte 0 done: return to WRITE for byte 1.
    - Byte 1 done: go to WAIT_STOP. Any further data bits are not ACKed.
  - READ: shifts out the next bit at each fall. After the 8th bit, at the next fall: SDA_OE=0, go to MACK.
  - MACK: samples the generator's ACK on the rise.
    - After byte 0: SDA_IN=0 returns to READ, driving bit 8 at the next fall; SDA_IN=1 (NACK) goes to WAIT_STOP.
    - After byte 1: go to WAIT_STOP whatever the value.
  - WAIT_STOP: SDA_OE=0; ignores everything except START/STOP.
- STOP in any state: go to IDLE in the next cycle with SDA_OE=0, SDA_OUT=1, BUSY=0. WR_DATA is retained.
- START in any state (repeated start): go to ADDR with bit_cnt=byte_cnt=0 and SDA_OE=0. A partial write word is discarded: no WR_STB, WR_DATA unchanged.
- rst=0 mid-transaction: immediately return to reset values. The bus is released within the same clock edge.
- Simultaneous START and rise cannot occur (SCL is stable high). If both rise and fall are seen at once (illegal), no action is taken.

Test Plan:
- Write 0xA55A to address 0x2A (SCL=clk/4) -> SDA_OE=1/SDA_OUT=0 during ACK clocks 9, 18 and 27; WR_DATA=16'hA55A; exactly one WR_STB pulse, after data rise 16; BUSY drops one clk after STOP.
- Read from 0x2A with RD_DATA=16'h3C81, generator ACKs byte 0 -> RD_STB pulses once; SDA_OUT bits on rises are 0011_1100 then 1000_0001; SDA_OE=0 in the MACK slots; return to IDLE after STOP.
- Address 0x15 (mismatch), write -> SDA_OE never asserts, BUSY stays 0, WR_STB never pulses, WR_DATA unchanged.
- Read with generator NACK after byte 0 -> no bits of byte 1 are driven; SDA_OE=0 until STOP; a subsequent write of 0x0001 completes correctly.
- Repeated START after 5 bits of write byte 1, then a full write of 0x1234 -> no strobe for the aborted word; WR_DATA=16'h1234 with one WR_STB.
- rst=0 held 1 clk while the target drives an ACK -> SDA_OE=0 and SDA_OUT=1 on the next edge, state IDLE, all outputs at reset values.
